// File: rtl/spi_reg_pkg.sv
// Frame constants, RW flag encoding and controller states shared by the SPI register
// slave and the APB-to-SPI master bridge.
package spi_reg_pkg;

    localparam int WR_FRAME_BITS = 49;
    localparam int RD_CMD_BITS   = 17;
    localparam int RD_DATA_BITS  = 32;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CMD      = 3'd1,
        WR_ISSUE = 3'd2,
        RD_ISSUE = 3'd3,
        RD_LATCH = 3'd4,
        RD_WAIT  = 3'd5,
        RD_SEND  = 3'd6
    } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, with rise/fall pulses derived
// from the synchronized copy.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic meta;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
            prev <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
            prev <= q;
        end
    end

    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/spi2reg_slave.sv
// SPI slave that decodes write/read register frames into a single-cycle register bus
// and returns read data on miso during the separate read data phase.
import spi_reg_pkg::*;

module spi2reg_slave #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int RD_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    output logic              reg_wr_en,
    output logic              reg_rd_en,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              frame_err,
    output logic              busy
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CMD_W   = 1 + ADDR_W;
    localparam int TO_W    = $clog2(RD_TIMEOUT + 1);
    localparam logic [5:0] CNT_MAX = 6'd63;

    state_e              state;
    logic                sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic                sclk_level_unused, cs_level_unused;
    logic                mosi_meta, mosi_sync;
    logic [5:0]          bit_cnt;
    logic [FRAME_W-1:0]  shift;
    logic [DATA_W-1:0]   tx;
    logic [TO_W-1:0]     wait_cnt;
    logic                frame_ok_wr, frame_ok_rd;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sclk),
        .q     (sclk_level_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cs),
        .q     (cs_level_unused),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            mosi_meta <= mosi;
            mosi_sync <= mosi_meta;
        end
    end

    // The RW flag is whichever bit arrived first, so its position depends on the length.
    assign frame_ok_wr = (bit_cnt == 6'(FRAME_W)) && (shift[FRAME_W-1] == RW_WRITE);
    assign frame_ok_rd = (bit_cnt == 6'(CMD_W))   && (shift[CMD_W-1]   == RW_READ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
        end else if (cs_fall) begin
            bit_cnt <= '0;
        end else if (sclk_rise && (state == CMD || state == RD_SEND) && bit_cnt != CNT_MAX) begin
            bit_cnt <= bit_cnt + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift <= '0;
        end else if (state == CMD && sclk_rise) begin
            shift <= {shift[FRAME_W-2:0], mosi_sync};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            reg_addr  <= '0;
            reg_wdata <= '0;
            tx        <= '0;
            wait_cnt  <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall) state <= CMD;
                end
                CMD: begin
                    if (cs_rise) begin
                        if (frame_ok_wr) begin
                            reg_addr  <= shift[FRAME_W-2 -: ADDR_W];
                            reg_wdata <= shift[DATA_W-1:0];
                            state     <= WR_ISSUE;
                        end else if (frame_ok_rd) begin
                            reg_addr <= shift[ADDR_W-1:0];
                            state    <= RD_ISSUE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                WR_ISSUE: state <= IDLE;
                RD_ISSUE: state <= RD_LATCH;
                RD_LATCH: begin
                    tx       <= reg_rdata;
                    wait_cnt <= '0;
                    state    <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (cs_fall) begin
                        state <= RD_SEND;
                    end else if (wait_cnt == TO_W'(RD_TIMEOUT - 1)) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
                end
                RD_SEND: begin
                    if (cs_rise) begin
                        if (bit_cnt != 6'(DATA_W)) frame_err <= 1'b1;
                        state <= IDLE;
                    end else if (sclk_fall) begin
                        tx <= {tx[DATA_W-2:0], 1'b0};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes decode straight from state so address/data loaded on entry are valid with them.
    assign reg_wr_en = (state == WR_ISSUE);
    assign reg_rd_en = (state == RD_ISSUE);
    assign busy      = (state != IDLE);
    assign miso      = (state == RD_SEND) && tx[DATA_W-1];

endmodule

// File: tb/tb_spi2reg_slave.sv
// Bench for spi2reg_slave: directed frame table, hand-written read/timeout/reset
// sequences, and random frames checked against a frame-level reference model.
module tb_spi2reg_slave;
    import spi_reg_pkg::*;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 32;
    localparam int RD_TIMEOUT = 255;
    localparam int HALF       = 5;
    localparam int NVEC       = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sclk  = 1'b0;
    logic cs    = 1'b1;
    logic mosi  = 1'b0;
    logic miso, reg_wr_en, reg_rd_en, frame_err, busy;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_wdata;
    logic [DATA_W-1:0] reg_rdata = '0;

    spi2reg_slave #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RD_TIMEOUT (RD_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .cs        (cs),
        .mosi      (mosi),
        .miso      (miso),
        .reg_wr_en (reg_wr_en),
        .reg_rd_en (reg_rd_en),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int rd_cnt   = 0;
    int err_cnt  = 0;
    int cyc      = 0;
    int last_rd_cyc  = 0;
    int last_err_cyc = 0;

    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [ADDR_W-1:0]        exp_rd_q[$];
    logic [DATA_W-1:0]        mem [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0]        ref_mem [logic [ADDR_W-1:0]];
    logic                     rd_pending = 1'b0;
    logic [ADDR_W-1:0]        rd_addr_q  = '0;

    typedef struct {
        string       name;
        logic [63:0] bits;
        int          n;
        int          d_wr;
        int          d_err;
        logic [15:0] exp_addr;
        logic [31:0] exp_wdata;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [63:0] wr_frame(input logic rw, input logic [15:0] a, input logic [31:0] d);
        return {15'b0, rw, a, d};
    endfunction

    function automatic logic [63:0] rd_frame(input logic rw, input logic [15:0] a);
        return {47'b0, rw, a};
    endfunction

    // Sends the low n bits of 'bits', MSB first; close=0 leaves cs low afterwards.
    task automatic send_bits(input logic [63:0] bits, input int n, input logic close);
        cs = 1'b0;
        wait_clks(HALF);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = bits[i];
            wait_clks(HALF);
            sclk = 1'b1;
            wait_clks(HALF);
            sclk = 1'b0;
        end
        if (close) begin
            wait_clks(HALF);
            cs   = 1'b1;
            mosi = 1'b0;
            wait_clks(6);
        end
    endtask

    // Data phase: miso is sampled just before each sclk rise, as the master does.
    task automatic read_phase(input int rises, output logic [31:0] got);
        got = '0;
        cs  = 1'b0;
        wait_clks(HALF);
        for (int i = 0; i < rises; i++) begin
            got  = {got[30:0], miso};
            sclk = 1'b1;
            wait_clks(HALF);
            sclk = 1'b0;
            wait_clks(HALF);
        end
        cs = 1'b1;
        wait_clks(6);
    endtask

    // Register file behind the bus plus the output monitor/scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (rd_pending) reg_rdata = mem.exists(rd_addr_q) ? mem[rd_addr_q] : '0;
        else            reg_rdata = $urandom;
        rd_pending = reg_rd_en;
        rd_addr_q  = reg_addr;
        if (reg_wr_en) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %h data %h, required no write", reg_addr, reg_wdata);
            end else begin
                check("write_addr_data", {reg_addr, reg_wdata}, exp_q.pop_front());
            end
            mem[reg_addr] = reg_wdata;
        end
        if (reg_rd_en) begin
            rd_cnt++;
            last_rd_cyc = cyc;
            if (exp_rd_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_read: got addr %h, required no read", reg_addr);
            end else begin
                check("read_addr", reg_addr, exp_rd_q.pop_front());
            end
        end
        if (frame_err) begin
            err_cnt++;
            last_err_cyc = cyc;
        end
        if (!busy) check("miso_idle", miso, 1'b0);
    end

    initial begin
        #800000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        vec_t        vecs[NVEC];
        int          base_wr, base_rd, base_err;
        int          exp_wr_tot, exp_rd_tot, exp_err_tot;
        int          sel, n, rises;
        logic [63:0] f;
        logic [15:0] a;
        logic [31:0] d, got, val, exp_v, exp_got;
        logic        rw, first;

        vecs[0] = '{"write_1234",  wr_frame(1'b1, 16'h1234, 32'hDEADBEEF), 49, 1, 0, 16'h1234, 32'hDEADBEEF};
        vecs[1] = '{"trunc_30",    wr_frame(1'b1, 16'h5555, 32'h12345678) >> 19, 30, 0, 1, 16'h1234, 32'hDEADBEEF};
        vecs[2] = '{"wr49_rw0",    wr_frame(1'b0, 16'h7777, 32'h11111111), 49, 0, 1, 16'h1234, 32'hDEADBEEF};
        vecs[3] = '{"rd17_rw1",    rd_frame(1'b1, 16'h0042), 17, 0, 1, 16'h1234, 32'hDEADBEEF};
        vecs[4] = '{"short_48",    wr_frame(1'b1, 16'h0F0F, 32'h0) >> 1, 48, 0, 1, 16'h1234, 32'hDEADBEEF};
        vecs[5] = '{"long_50",     wr_frame(1'b1, 16'h3C3C, 32'hA5A5A5A5) << 1, 50, 0, 1, 16'h1234, 32'hDEADBEEF};
        vecs[6] = '{"write_ffff",  wr_frame(1'b1, 16'hFFFF, 32'h00000000), 49, 1, 0, 16'hFFFF, 32'h00000000};
        vecs[7] = '{"write_0000",  wr_frame(1'b1, 16'h0000, 32'hFFFFFFFF), 49, 1, 0, 16'h0000, 32'hFFFFFFFF};
        vecs[8] = '{"single_bit",  64'h1, 1, 0, 1, 16'h0000, 32'hFFFFFFFF};
        vecs[9] = '{"empty_frame", 64'h0, 0, 0, 1, 16'h0000, 32'hFFFFFFFF};

        // Reset state
        wait_clks(4);
        check("rst_wr_en", reg_wr_en, 1'b0);
        check("rst_rd_en", reg_rd_en, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_miso", miso, 1'b0);
        check("rst_addr_wdata", {reg_addr, reg_wdata}, 48'h0);
        rst_n = 1'b1;
        wait_clks(4);

        // Directed frame table
        for (int i = 0; i < NVEC; i++) begin
            base_wr  = wr_cnt;
            base_err = err_cnt;
            if (vecs[i].d_wr != 0) exp_q.push_back({vecs[i].exp_addr, vecs[i].exp_wdata});
            send_bits(vecs[i].bits, vecs[i].n, 1'b1);
            check({vecs[i].name, "_wr"}, wr_cnt - base_wr, vecs[i].d_wr);
            check({vecs[i].name, "_err"}, err_cnt - base_err, vecs[i].d_err);
            check({vecs[i].name, "_addr"}, reg_addr, vecs[i].exp_addr);
            check({vecs[i].name, "_wdata"}, reg_wdata, vecs[i].exp_wdata);
            check({vecs[i].name, "_busy"}, busy, 1'b0);
        end

        // Read 0x00A5 with a 50-clk gap before the data phase
        mem[16'h00A5] = 32'hCAFE0001;
        base_rd  = rd_cnt;
        base_err = err_cnt;
        exp_rd_q.push_back(16'h00A5);
        send_bits(rd_frame(RW_READ, 16'h00A5), 17, 1'b1);
        check("rd_a5_busy_gap", busy, 1'b1);
        wait_clks(50);
        read_phase(32, got);
        check("rd_a5_data", got, 32'hCAFE0001);
        check("rd_a5_strobe", rd_cnt - base_rd, 1);
        check("rd_a5_err", err_cnt - base_err, 0);
        check("rd_a5_addr", reg_addr, 16'h00A5);
        check("rd_a5_busy", busy, 1'b0);

        // Read command with no data phase: timeout, then a normal write
        base_err = err_cnt;
        exp_rd_q.push_back(16'h0003);
        send_bits(rd_frame(RW_READ, 16'h0003), 17, 1'b1);
        wait_clks(300);
        check("timeout_err", err_cnt - base_err, 1);
        check("timeout_window", (last_err_cyc - last_rd_cyc >= RD_TIMEOUT) &&
                                (last_err_cyc - last_rd_cyc <= RD_TIMEOUT + 5), 1'b1);
        check("timeout_busy", busy, 1'b0);
        base_wr  = wr_cnt;
        base_err = err_cnt;
        exp_q.push_back({16'h0002, 32'h5});
        send_bits(wr_frame(RW_WRITE, 16'h0002, 32'h5), 49, 1'b1);
        check("after_timeout_wr", wr_cnt - base_wr, 1);
        check("after_timeout_err", err_cnt - base_err, 0);

        // Reset at bit 20 of a write
        base_wr  = wr_cnt;
        base_err = err_cnt;
        send_bits(wr_frame(RW_WRITE, 16'h0BAD, 32'h0BADF00D) >> 29, 20, 1'b0);
        rst_n = 1'b0;
        wait_clks(2);
        cs   = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        wait_clks(2);
        check("midrst_busy", busy, 1'b0);
        check("midrst_addr_wdata", {reg_addr, reg_wdata}, 48'h0);
        rst_n = 1'b1;
        wait_clks(4);
        check("midrst_no_wr", wr_cnt - base_wr, 0);
        check("midrst_no_err", err_cnt - base_err, 0);
        exp_q.push_back({16'h0010, 32'h1});
        send_bits(wr_frame(RW_WRITE, 16'h0010, 32'h1), 49, 1'b1);
        check("postrst_wr", wr_cnt - base_wr, 1);
        check("postrst_addr", reg_addr, 16'h0010);

        // Write then immediate read of the same register; then short and long data phases
        val = $urandom;
        base_err = err_cnt;
        exp_q.push_back({16'h0001, val});
        send_bits(wr_frame(RW_WRITE, 16'h0001, val), 49, 1'b1);
        exp_rd_q.push_back(16'h0001);
        send_bits(rd_frame(RW_READ, 16'h0001), 17, 1'b1);
        wait_clks(20);
        read_phase(32, got);
        check("wr_rd_data", got, val);
        check("wr_rd_err", err_cnt - base_err, 0);
        exp_rd_q.push_back(16'h0001);
        send_bits(rd_frame(RW_READ, 16'h0001), 17, 1'b1);
        wait_clks(20);
        read_phase(16, got);
        check("abort16_bits", got[15:0], val[31:16]);
        check("abort16_err", err_cnt - base_err, 1);
        exp_rd_q.push_back(16'h0001);
        send_bits(rd_frame(RW_READ, 16'h0001), 17, 1'b1);
        wait_clks(20);
        read_phase(33, got);
        check("over33_bits", got, {val[30:0], 1'b0});
        check("over33_err", err_cnt - base_err, 2);
        check("over33_busy", busy, 1'b0);

        // Random frames against the frame-level reference model
        exp_wr_tot  = wr_cnt;
        exp_rd_tot  = rd_cnt;
        exp_err_tot = err_cnt;
        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(0, 9);
            a   = 16'h0100 + 16'($urandom_range(0, 7));
            d   = $urandom;
            if (sel < 4) begin
                n  = 49;
                rw = ($urandom_range(0, 3) != 0);
                f  = wr_frame(rw, a, d);
            end else if (sel < 8) begin
                n  = 17;
                rw = ($urandom_range(0, 3) == 0);
                f  = rd_frame(rw, a);
            end else begin
                n = $urandom_range(0, 55);
                f = {$urandom, $urandom};
            end
            first = (n > 0) ? f[n-1] : 1'b0;
            if (n == WR_FRAME_BITS && first == RW_WRITE) begin
                exp_wr_tot++;
                exp_q.push_back(f[47:0]);
                ref_mem[f[47:32]] = f[31:0];
            end else if (n == RD_CMD_BITS && first == RW_READ) begin
                exp_rd_tot++;
                exp_rd_q.push_back(f[15:0]);
            end else begin
                exp_err_tot++;
            end
            send_bits(f, n, 1'b1);
            if (n == RD_CMD_BITS && first == RW_READ) begin
                wait_clks($urandom_range(10, 60));
                rises = ($urandom_range(0, 3) != 0) ? 32 : $urandom_range(1, 40);
                if (rises != RD_DATA_BITS) exp_err_tot++;
                exp_v   = ref_mem.exists(f[15:0]) ? ref_mem[f[15:0]] : 32'h0;
                exp_got = (rises <= 32) ? (exp_v >> (32 - rises)) : (exp_v << (rises - 32));
                read_phase(rises, got);
                check("rand_rd_data", got, exp_got);
            end
            check("rand_wr_cnt", wr_cnt, exp_wr_tot);
            check("rand_rd_cnt", rd_cnt, exp_rd_tot);
            check("rand_err_cnt", err_cnt, exp_err_tot);
            check("rand_busy", busy, 1'b0);
            wait_clks($urandom_range(0, 5));
        end

        check("exp_q_drained", exp_q.size(), 0);
        check("exp_rd_q_drained", exp_rd_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi2reg_slave.md
Name: spi2reg_slave

Overview:
- SPI slave endpoint for the serial register protocol driven by the team's APB-to-SPI master bridge.
- Decodes write frames and read frames arriving on sclk/cs/mosi and turns them into a simple single-cycle register bus.
- Returns read data on miso during the read data phase.
- Sits at the far (peripheral) end of the SPI link and drives a local register file.

Parameters:
ADDR_W, 16, register address width; the frame address field width.
DATA_W, 32, register data width; the frame data field width.
RD_TIMEOUT, 255, clk cycles allowed in RD_WAIT before abandoning a read.

Ports:
clk  in  1  system clock, at least 8x the sclk frequency
rst_n  in  1  reset
sclk  in  1  SPI clock, idle low, asynchronous to clk
cs  in  1  chip select, active low, asynchronous
mosi  in  1  serial data in
miso  out  1  serial data out
reg_wr_en  out  1  one-cycle write strobe
reg_rd_en  out  1  one-cycle read strobe
reg_addr  out  ADDR_W  register address
reg_wdata  out  DATA_W  register write data
reg_rdata  in  DATA_W  read data, valid exactly 1 clk after reg_rd_en
frame_err  out  1  one-cycle pulse on malformed or aborted frame
busy  out  1  high whenever the state machine is not in IDLE

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. All outputs reset to 0 and the state machine resets to IDLE.
- Input sync and edge detect:
  - sclk, cs and mosi each pass through a 2-flop synchronizer.
  - Edges are detected on the synced signals: sclk_rise, sclk_fall, cs_fall, cs_rise.
- Frame format (MSB first; mosi sampled on sclk_rise):
  - Write frame, 49 bits: {1'b1, addr[15:0], data[31:0]}.
  - Read command frame, 17 bits: {1'b0, addr[15:0]}.
  - After the read command, cs goes high for a gap, then drops again for a 32-bit data phase in which the slave drives miso.
- Bit counter: 6 bits, saturates at 63, cleared on cs_fall.
- States:
  - IDLE: cs_fall -> CMD.
  - CMD: shift mosi into a 49-bit shift register on each sclk_rise. On cs_rise:
    - first bit = 1 and count = 49 -> WR_ISSUE;
    - first bit = 0 and count = 17 -> RD_ISSUE;
    - otherwise pulse frame_err and go to IDLE; the register bus is untouched.
  - WR_ISSUE (1 cycle): reg_addr and reg_wdata load from the shift register; reg_wr_en = 1; next state IDLE.
  - RD_ISSUE (1 cycle): reg_addr loads; reg_rd_en = 1; next state RD_LATCH.
  - RD_LATCH (1 cycle): capture reg_rdata into a 32-bit tx shift register; next state RD_WAIT.
  - RD_WAIT: wait with cs high.
    - cs_fall -> RD_SEND, with miso = tx[31] on that same cycle.
    - If the timeout counter reaches RD_TIMEOUT first: pulse frame_err, go to IDLE.
  - RD_SEND:
    - On each sclk_fall, shift tx left and drive the next bit.
    - mosi is ignored.
    - cs_rise after exactly 32 sclk_rise -> IDLE.
    - cs_rise earlier, or more than 32 rises -> frame_err pulse, then IDLE.
- Output hold and miso rules:
  - reg_addr and reg_wdata hold their value until the next WR_ISSUE or RD_ISSUE.
  - miso = 0 outside RD_SEND; there is no tristate.
- Timing margin: with 2-flop sync, the miso update lands at most 3 clk after the master's sclk fall or cs fall. The master samples 5 clk later, so the protocol requires clk >= 8x sclk.
- Reset mid-frame: returns to IDLE immediately. A partial frame is discarded with no strobe and no frame_err.
- A cs_fall detected in CMD restarts frame capture (count cleared). This is not reachable under a clean protocol.
- Back-to-back frames are allowed: after WR_ISSUE, the IDLE state accepts cs_fall on the very next cycle.

Decomposition:
- Shared package spi_reg_pkg holds:
  - frame constants WR_FRAME_BITS = 49, RD_CMD_BITS = 17, RD_DATA_BITS = 32;
  - the RW flag encoding (1 = write);
  - the state enum IDLE, CMD, WR_ISSUE, RD_ISSUE, RD_LATCH, RD_WAIT, RD_SEND.
- The APB-to-SPI master imports the same frame constants.
- One sub-module: spi_sync_edge. It is a parameterized 2-flop synchronizer plus rise/fall detect, instantiated for sclk and cs. mosi uses the sync only.

Test Plan:
- Write frame, addr 0x1234, data 0xDEADBEEF, 10 clk per bit -> single reg_wr_en pulse with reg_addr = 0x1234 and reg_wdata = 0xDEADBEEF; frame_err never asserted; busy returns to 0.
- Read command addr 0x00A5, 50-clk gap, 32-bit data phase; register model returns 0xCAFE0001 -> reg_rd_en pulse with reg_addr = 0x00A5; bits sampled on master sclk rise reassemble to 0xCAFE0001.
- Write frame truncated, cs rises after 30 bits -> frame_err pulse, no reg_wr_en, reg_addr unchanged.
- Read command, then no data phase for 300 clk -> frame_err at cycle RD_TIMEOUT; state is IDLE; a following write to 0x0002 with data 0x5 completes normally.
- rst_n asserted at bit 20 of a write, then released; then a full write addr 0x0010, data 0x1 -> no strobe from the aborted frame; exactly one reg_wr_en for 0x0010/0x1.
- Write to 0x0001 followed immediately by a read of 0x0001, with the register model updated by the write -> read returns the just-written data; data phase aborted after 16 bits -> frame_err.
